// File: rtl/pipelined_shifter_if.sv
// Operand/result handshake bundle for the pipelined shifter.
// master = producer/consumer side, slave = the shifter itself.
interface pipelined_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int LOG2W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LOG2W-1:0] in_shamt;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR plus pass-through.
// The log2(WIDTH) power-of-two steps are spread over STAGES register
// stages; each stage has its own valid bit and a ready chain so a stalled
// output back-pressures only as far as there are full stages.

// One pipeline stage: the shift steps it owns, followed by its register.
module pipelined_shifter_stage #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    parameter int LOG2W  = 5,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             ld,
    input  logic             v_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [LOG2W-1:0] sh_i,
    input  logic [2:0]       op_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             s_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o,
    output logic [LOG2W-1:0] sh_o,
    output logic [2:0]       op_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             s_o
);
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic [WIDTH-1:0] d_sh;

    // Apply every step k with floor(k*STAGES/LOG2W) == IDX; steps compose
    // because each op is closed under repeated application.
    always_comb begin
        d_sh = d_i;
        for (int k = 0; k < LOG2W; k++) begin
            if (((k * STAGES) / LOG2W) == IDX && sh_i[k]) begin
                case (op_i)
                    OP_SLL:  d_sh = d_sh << (1 << k);
                    OP_SRL:  d_sh = d_sh >> (1 << k);
                    OP_SRA:  d_sh = (d_sh >> (1 << k)) | ({WIDTH{s_i}} << (WIDTH - (1 << k)));
                    OP_ROL:  d_sh = (d_sh << (1 << k)) | (d_sh >> (WIDTH - (1 << k)));
                    OP_ROR:  d_sh = (d_sh >> (1 << k)) | (d_sh << (WIDTH - (1 << k)));
                    default: d_sh = d_sh;
                endcase
            end
        end
    end

    // Stage register: flush kills validity, otherwise load when there is room
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_o   <= 1'b0;
            d_o   <= '0;
            sh_o  <= '0;
            op_o  <= '0;
            tag_o <= '0;
            s_o   <= 1'b0;
        end else if (flush) begin
            v_o <= 1'b0;
        end else if (ld) begin
            v_o   <= v_i;
            d_o   <= d_sh;
            sh_o  <= sh_i;
            op_o  <= op_i;
            tag_o <= tag_i;
            s_o   <= s_i;
        end
    end
endmodule

module pipelined_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    pipelined_shifter_if.slave  bus
);
    localparam int LOG2W = $clog2(WIDTH);

    // Index 0 is the input port, index s+1 is the register of stage s.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0]            rdy;
    logic [STAGES:0][WIDTH-1:0] dat_pipe;
    logic [STAGES:0][LOG2W-1:0] sh_pipe;
    logic [STAGES:0][2:0]       op_pipe;
    logic [STAGES:0][TAG_W-1:0] tag_pipe;
    logic [STAGES:0]            sgn_pipe;
    logic                       unused_tail;

    assign vld_pipe[0] = bus.in_valid;
    assign dat_pipe[0] = bus.in_data;
    assign sh_pipe[0]  = bus.in_shamt;
    assign op_pipe[0]  = bus.in_op;
    assign tag_pipe[0] = bus.in_tag;
    assign sgn_pipe[0] = bus.in_data[WIDTH-1];

    // Ready ripples back from the consumer: a stage can take data if it is
    // empty or its own contents move on this cycle.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = bus.out_ready;
        for (int s = STAGES - 1; s >= 0; s--)
            rdy[s] = !vld_pipe[s+1] || rdy[s+1];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        pipelined_shifter_stage #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .TAG_W (TAG_W),
            .LOG2W (LOG2W),
            .IDX   (s)
        ) u_stage (
            .clk    (clk),
            .reset_n(reset_n),
            .flush  (flush),
            .ld     (rdy[s]),
            .v_i    (vld_pipe[s]),
            .d_i    (dat_pipe[s]),
            .sh_i   (sh_pipe[s]),
            .op_i   (op_pipe[s]),
            .tag_i  (tag_pipe[s]),
            .s_i    (sgn_pipe[s]),
            .v_o    (vld_pipe[s+1]),
            .d_o    (dat_pipe[s+1]),
            .sh_o   (sh_pipe[s+1]),
            .op_o   (op_pipe[s+1]),
            .tag_o  (tag_pipe[s+1]),
            .s_o    (sgn_pipe[s+1])
        );
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_data  = dat_pipe[STAGES];
    assign bus.out_tag   = tag_pipe[STAGES];

    // Control fields leaving the last stage have no consumer.
    assign unused_tail = ^{sh_pipe[STAGES], op_pipe[STAGES], sgn_pipe[STAGES]};
endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed cases, streaming, backpressure,
// flush and asynchronous reset on a 32-bit/2-stage instance, plus a random
// sweep over six width/stage configurations against a bit-level model.
module tb_pipelined_shifter;
    logic clk;
    logic rst_n;
    logic flush;
    int   n_vec = 0;
    int   n_err = 0;

    pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) m();
    pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .reset_n(rst_n), .flush(flush), .bus(m)
    );

    // Sweep instances share one stimulus, truncated to each width.
    logic        sw_v;
    logic [63:0] sw_d;
    logic [5:0]  sw_sh;
    logic [2:0]  sw_op;
    logic [4:0]  sw_tag;
    logic        sw_ov [6];
    logic        sw_ir [6];
    logic [63:0] sw_od [6];
    logic [4:0]  sw_ot [6];

    for (genvar g = 0; g < 6; g++) begin : g_sw
        localparam int W = (g < 2) ? 8 : ((g < 4) ? 32 : 64);
        localparam int S = (g % 2 == 0) ? 1 : $clog2(W);
        pipelined_shifter_if #(.WIDTH(W), .TAG_W(5)) b();
        assign b.in_valid  = sw_v;
        assign b.in_data   = sw_d[W-1:0];
        assign b.in_shamt  = sw_sh[$clog2(W)-1:0];
        assign b.in_op     = sw_op;
        assign b.in_tag    = sw_tag;
        assign b.out_ready = 1'b1;
        assign sw_ov[g] = b.out_valid;
        assign sw_ir[g] = b.in_ready;
        assign sw_od[g] = 64'(b.out_data);
        assign sw_ot[g] = b.out_tag;
        pipelined_shifter #(.WIDTH(W), .STAGES(S), .TAG_W(5)) u_dut (
            .clk(clk), .reset_n(rst_n), .flush(1'b0), .bus(b)
        );
    end

    function automatic int cfg_w(input int g);
        return (g < 2) ? 8 : ((g < 4) ? 32 : 64);
    endfunction

    function automatic int cfg_s(input int g);
        return (g % 2 == 0) ? 1 : $clog2(cfg_w(g));
    endfunction

    // Reference: each result bit is picked from its source bit position.
    function automatic logic [63:0] ref_shift(input int w, input logic [63:0] d,
                                              input int n, input logic [2:0] op);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                3'd0:    r[i] = (i - n >= 0) ? d[i-n] : 1'b0;
                3'd1:    r[i] = (i + n < w) ? d[i+n] : 1'b0;
                3'd2:    r[i] = (i + n < w) ? d[i+n] : d[w-1];
                3'd3:    r[i] = d[(i - n + w) % w];
                3'd4:    r[i] = d[(i + n) % w];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] ref32(input logic [31:0] d, input logic [4:0] n,
                                          input logic [2:0] op);
        logic [63:0] r;
        r = ref_shift(32, {32'b0, d}, int'(n), op);
        return r[31:0];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed table
    logic [31:0] dir_d [7] = '{32'h80000000, 32'h80000000, 32'h00000001, 32'h000000F1,
                               32'h80000001, 32'h12345678, 32'h80000000};
    logic [4:0]  dir_s [7] = '{5'd4, 5'd4, 5'd31, 5'd4, 5'd1, 5'd7, 5'd0};
    logic [2:0]  dir_o [7] = '{3'd2, 3'd1, 3'd0, 3'd4, 3'd3, 3'd5, 3'd2};
    logic [31:0] dir_e [7] = '{32'hF8000000, 32'h08000000, 32'h80000000, 32'h1000000F,
                               32'h00000003, 32'h12345678, 32'h80000000};
    logic [4:0]  dir_t [7] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};

    // Offer one op with no backpressure and count edges until it appears.
    task automatic run_one(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] op,
                           input logic [4:0] tg, output logic [31:0] rd,
                           output logic [4:0] rt, output int lat);
        @(negedge clk);
        m.out_ready = 1'b1;
        m.in_valid  = 1'b1;
        m.in_data   = d;
        m.in_shamt  = sh;
        m.in_op     = op;
        m.in_tag    = tg;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        m.in_valid = 1'b0;
        while (!m.out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd = m.out_data;
        rt = m.out_tag;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_vec++; if (m.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", m.out_valid); end
        n_vec++; if (m.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", m.out_data); end
        n_vec++; if (m.out_tag !== 5'h0) begin n_err++; $display("FAIL reset_out_tag got %h want 0", m.out_tag); end
        n_vec++; if (m.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", m.in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (m.out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid got %b want 0", m.out_valid); end
        n_vec++; if (m.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", m.in_ready); end
    endtask

    task automatic test_directed;
        logic [31:0] rd;
        logic [4:0]  rt;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            run_one(dir_d[i], dir_s[i], dir_o[i], dir_t[i], rd, rt, lat);
            n_vec++; if (rd !== dir_e[i]) begin n_err++; $display("FAIL directed[%0d]_data got %h want %h", i, rd, dir_e[i]); end
            n_vec++; if (rt !== dir_t[i]) begin n_err++; $display("FAIL directed[%0d]_tag got %0d want %0d", i, rt, dir_t[i]); end
            n_vec++; if (lat != 2) begin n_err++; $display("FAIL directed[%0d]_latency got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] bd [8];
        logic [4:0]  bs [8];
        logic [2:0]  bo [8];
        int          idx;
        m.out_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            idx = c - 2;
            if (idx >= 0 && idx < 8) begin
                n_vec++; if (m.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b[%0d]_valid got %b want 1", c, m.out_valid); end
                n_vec++; if (m.out_tag !== 5'(idx)) begin n_err++; $display("FAIL b2b[%0d]_tag got %0d want %0d", c, m.out_tag, idx); end
                n_vec++; if (m.out_data !== ref32(bd[idx], bs[idx], bo[idx])) begin
                    n_err++; $display("FAIL b2b[%0d]_data got %h want %h", c, m.out_data, ref32(bd[idx], bs[idx], bo[idx])); end
            end else begin
                n_vec++; if (m.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b[%0d]_idle got %b want 0", c, m.out_valid); end
            end
            if (c < 8) begin
                bd[c] = $urandom;
                bs[c] = 5'($urandom_range(0, 31));
                bo[c] = 3'($urandom_range(0, 7));
                m.in_valid = 1'b1;
                m.in_data  = bd[c];
                m.in_shamt = bs[c];
                m.in_op    = bo[c];
                m.in_tag   = 5'(c);
            end else begin
                m.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d [3];
        logic [4:0]  s [3];
        logic [2:0]  o [3];
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            s[i] = 5'($urandom_range(1, 31));
            o[i] = 3'(i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m.out_ready = 1'b0;
            m.in_valid  = 1'b1;
            m.in_data   = d[i];
            m.in_shamt  = s[i];
            m.in_op     = o[i];
            m.in_tag    = 5'(20 + i);
            #1;
            n_vec++; if (m.in_ready !== (i < 2)) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want %b", i, m.in_ready, (i < 2)); end
            @(posedge clk);
        end
        @(negedge clk);
        n_vec++; if (m.out_valid !== 1'b1 || m.out_data !== ref32(d[0], s[0], o[0]) || m.out_tag !== 5'd20) begin
            n_err++; $display("FAIL bp_hold got v=%b %h/%0d want v=1 %h/20", m.out_valid, m.out_data, m.out_tag, ref32(d[0], s[0], o[0])); end
        n_vec++; if (m.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b want 0", m.in_ready); end
        m.out_ready = 1'b1;
        #1;
        n_vec++; if (m.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_passback_ready got %b want 1", m.in_ready); end
        @(posedge clk);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            m.in_valid = 1'b0;
            n_vec++; if (m.out_valid !== 1'b1 || m.out_data !== ref32(d[i], s[i], o[i]) || m.out_tag !== 5'(20 + i)) begin
                n_err++; $display("FAIL bp_drain[%0d] got v=%b %h/%0d want v=1 %h/%0d", i, m.out_valid, m.out_data, m.out_tag, ref32(d[i], s[i], o[i]), 20 + i); end
            @(posedge clk);
        end
        @(negedge clk);
        n_vec++; if (m.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", m.out_valid); end
    endtask

    task automatic test_flush;
        logic [31:0] rd;
        logic [4:0]  rt;
        int          lat;
        m.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m.in_valid = 1'b1;
            m.in_data  = $urandom;
            m.in_shamt = 5'd3;
            m.in_op    = 3'd0;
            m.in_tag   = 5'(10 + i);
            @(posedge clk);
        end
        @(negedge clk);
        m.out_ready = 1'b0;
        flush       = 1'b1;
        m.in_tag    = 5'd12;
        @(posedge clk);
        @(negedge clk);
        flush       = 1'b0;
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
        n_vec++; if (m.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", m.out_valid); end
        n_vec++; if (m.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", m.in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (m.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stale[%0d] got %b want 0", i, m.out_valid); end
        end
        run_one(32'hA5A5_0F0F, 5'd8, 3'd4, 5'd13, rd, rt, lat);
        n_vec++; if (rd !== 32'h0FA5_A50F || rt !== 5'd13) begin n_err++; $display("FAIL flush_new got %h/%0d want 0fa5a50f/13", rd, rt); end
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL flush_latency got %0d want 2", lat); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic [4:0]  rt;
        int          lat;
        m.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m.in_valid = 1'b1;
            m.in_data  = $urandom | 32'h1;
            m.in_shamt = 5'd1;
            m.in_op    = 3'd3;
            m.in_tag   = 5'(25 + i);
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (m.out_valid !== 1'b0 || m.out_data !== 32'h0 || m.out_tag !== 5'h0) begin
            n_err++; $display("FAIL async_reset got v=%b %h/%0d want v=0 0/0", m.out_valid, m.out_data, m.out_tag); end
        n_vec++; if (m.in_ready !== 1'b1) begin n_err++; $display("FAIL async_reset_ready got %b want 1", m.in_ready); end
        @(negedge clk);
        m.in_valid = 1'b0;
        rst_n      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (m.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_stale[%0d] got %b want 0", i, m.out_valid); end
        end
        run_one(32'h8000_0001, 5'd1, 3'd3, 5'd30, rd, rt, lat);
        n_vec++; if (rd !== 32'h0000_0003 || rt !== 5'd30) begin n_err++; $display("FAIL reset_new got %h/%0d want 00000003/30", rd, rt); end
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL reset_new_latency got %0d want 2", lat); end
    endtask

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
    } res_t;

    task automatic test_random;
        res_t        q[$];
        res_t        e;
        logic        hold;
        logic [31:0] hold_d;
        logic [4:0]  hold_t;
        hold = 1'b0;
        hold_d = '0;
        hold_t = '0;
        for (int c = 0; c < 308; c++) begin
            @(negedge clk);
            if (c < 300) begin
                m.in_valid  = ($urandom_range(0, 3) != 0);
                m.in_data   = $urandom;
                m.in_shamt  = (c % 16 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                m.in_op     = 3'($urandom_range(0, 7));
                m.in_tag    = 5'($urandom_range(0, 31));
                m.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                m.in_valid  = 1'b0;
                m.out_ready = 1'b1;
            end
            #1;
            if (hold) begin
                n_vec++; if (m.out_valid !== 1'b1 || m.out_data !== hold_d || m.out_tag !== hold_t) begin
                    n_err++; $display("FAIL rnd_stable[%0d] got v=%b %h/%0d want v=1 %h/%0d", c, m.out_valid, m.out_data, m.out_tag, hold_d, hold_t); end
            end
            if (m.out_valid && m.out_ready) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rnd_spurious[%0d] got result %h with nothing outstanding", c, m.out_data);
                end else begin
                    e = q.pop_front();
                    n_vec++; if (m.out_data !== e.d || m.out_tag !== e.t) begin
                        n_err++; $display("FAIL rnd_result[%0d] got %h/%0d want %h/%0d", c, m.out_data, m.out_tag, e.d, e.t); end
                end
            end
            hold   = m.out_valid && !m.out_ready;
            hold_d = m.out_data;
            hold_t = m.out_tag;
            if (m.in_valid && m.in_ready) begin
                e.d = ref32(m.in_data, m.in_shamt, m.in_op);
                e.t = m.in_tag;
                q.push_back(e);
            end
        end
        n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_lost got %0d outstanding want 0", q.size()); end
    endtask

    task automatic test_sweep;
        localparam int N = 40;
        logic [63:0] hd [N];
        logic [5:0]  hs [N];
        logic [2:0]  ho [N];
        logic [4:0]  ht [N];
        logic [63:0] e;
        int          w;
        int          idx;
        for (int c = 0; c < N + 8; c++) begin
            @(negedge clk);
            for (int g = 0; g < 6; g++) begin
                w   = cfg_w(g);
                idx = c - cfg_s(g);
                n_vec++; if (sw_ov[g] !== (idx >= 0 && idx < N)) begin
                    n_err++; $display("FAIL sweep_valid w=%0d s=%0d c=%0d got %b want %b", w, cfg_s(g), c, sw_ov[g], (idx >= 0 && idx < N)); end
                n_vec++; if (sw_ir[g] !== 1'b1) begin n_err++; $display("FAIL sweep_ready w=%0d c=%0d got %b want 1", w, c, sw_ir[g]); end
                if (idx >= 0 && idx < N) begin
                    e = ref_shift(w, hd[idx], int'(hs[idx]) % w, ho[idx]);
                    n_vec++; if (sw_od[g] !== e || sw_ot[g] !== ht[idx]) begin
                        n_err++; $display("FAIL sweep_data w=%0d s=%0d c=%0d got %h/%0d want %h/%0d", w, cfg_s(g), c, sw_od[g], sw_ot[g], e, ht[idx]); end
                end
            end
            if (c < N) begin
                hd[c] = {$urandom, $urandom};
                hs[c] = (c % 8 == 0) ? 6'd0 : 6'($urandom_range(0, 63));
                ho[c] = 3'($urandom_range(0, 7));
                ht[c] = 5'($urandom_range(0, 31));
                sw_v   = 1'b1;
                sw_d   = hd[c];
                sw_sh  = hs[c];
                sw_op  = ho[c];
                sw_tag = ht[c];
            end else begin
                sw_v = 1'b0;
            end
        end
    endtask

    initial begin
        flush       = 1'b0;
        m.in_valid  = 1'b0;
        m.in_data   = '0;
        m.in_shamt  = '0;
        m.in_op     = '0;
        m.in_tag    = '0;
        m.out_ready = 1'b1;
        sw_v   = 1'b0;
        sw_d   = '0;
        sw_sh  = '0;
        sw_op  = '0;
        sw_tag = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
Parametrised, pipelined barrel shifter for the frisc execute path. It supports logical and arithmetic shifts plus rotates in both directions, and passes a tag through alongside the data. The log2(WIDTH) shift steps are spread over STAGES register stages, with a valid/ready handshake and backpressure at each stage. It lets the ALU shifter be retimed independently of the rest of the datapath.

Parameters:
WIDTH, 32, data width; power of two, >= 2; LOG2W = $clog2(WIDTH).
STAGES, 2, number of pipeline register stages; 1 <= STAGES <= LOG2W.
TAG_W, 5, width of the opaque tag carried with each operation (e.g. rd index).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous kill of all in-flight operations.
in_valid  input  1  operation offered.
in_ready  output  1  pipeline accepts an operation this cycle.
in_data  input  WIDTH  operand.
in_shamt  input  LOG2W  shift amount.
in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through.
in_tag  input  TAG_W  tag carried unchanged to the output.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
out_data  output  WIDTH  shifted result.
out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (reset_n low, asynchronous): all stage valid bits = 0, all stage data and tag registers = 0. Outputs during and after reset: out_valid=0, out_data=0, out_tag=0, in_ready=1. Any in-flight operations are discarded.
- Step decomposition: step k (k = 0..LOG2W-1) shifts by 2^k when shamt[k]=1. Step k executes in the combinational logic feeding stage s = floor(k*STAGES/LOG2W). Each stage register holds the partial data, the remaining shamt bits, the op, the tag, and the sign bit.
- SRA sign fill uses in_data[WIDTH-1], captured at entry. SRL/SLL fill with 0. ROL/ROR wrap the bits modulo WIDTH. Pass-through ops ignore in_shamt. A shamt of 0 returns in_data for every op.
- Handshake: each stage has valid bit v[s]. ready[s] = !v[s] || ready[s+1], with ready[STAGES] = out_ready. in_ready = ready[0].
- Stage s loads from stage s-1 (or the input for s=0) when ready[s]=1. In that case v[s] <= v[s-1] (or in_valid); otherwise the stage holds.
- out_valid = v[STAGES-1]. out_data and out_tag are the final stage registers. They stay stable while out_valid=1 and out_ready=0.
- Latency: exactly STAGES cycles from an accepted input to out_valid when there is no backpressure. Throughput is 1 operation per cycle.
- Full: all v=1 and out_ready=0 gives in_ready=0, and no input is accepted. When out_ready goes 1, in_ready=1 in the same cycle (combinational pass-back), so there are no bubbles.
- Simultaneous input accept and output drain on a full pipeline: both happen and the occupancy is unchanged.
- Ordering: results leave in acceptance order. No operation is duplicated or dropped except by flush or reset.
- flush=1 at a clock edge: all v <= 0 and data registers are don't-care. The input offered in that cycle is not accepted. in_ready=1 the next cycle. flush has priority over all loads.
- Reset mid-operation: same as the reset values above, effective immediately (asynchronously). The first result after reset_n deasserts comes only from a new input.
- STAGES=1: single register stage with the full barrel shift in front of it.

Test Plan:
- WIDTH=32, STAGES=2, SRA 0x80000000 by 4, tag 3 -> after 2 cycles out_data=0xF8000000, out_tag=3. SRL of the same operand -> 0x08000000.
- SLL 0x00000001 by 31 -> 0x80000000. ROR 0x000000F1 by 4 -> 0x1000000F. ROL 0x80000001 by 1 -> 0x00000003. Op 101 on 0x12345678 by 7 -> 0x12345678.
- Back-to-back stream of 8 ops with out_ready=1 -> 8 results on 8 consecutive cycles starting at cycle 2, in order, with tags 0..7.
- Backpressure: out_ready=0 while 3 ops are offered -> 2 accepted, in_ready=0 on the 3rd, out_valid=1 with data held stable. out_ready=1 -> 3rd accepted the same cycle, and all 3 results emerge in order.
- flush with 2 ops in flight -> next cycle out_valid=0, in_ready=1. The new op after flush emerges alone after 2 cycles.
- reset_n pulsed low mid-stream between clock edges -> out_valid=0, out_data=0, out_tag=0 immediately. After release there are no stale results, and a new op completes in 2 cycles.
- Sweep WIDTH in {8,32,64} x STAGES in {1, LOG2W} with random ops vs. a reference model -> no mismatches and latency == STAGES.
